// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver with a show-ahead scan-code FIFO.
// Optional build macro BREAK_FILTER_EN strips E0/F0 prefixes and break codes.
module ps2_scancode_receiver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       rd_en,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers reset to the idle-high line level so release causes no false fall.
    logic [1:0] clk_sync, dat_sync;
    logic       clk_prev;
    logic       fall, dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values.
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev && !clk_sync[1];
    assign dat  = dat_sync[1];

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          byte_ok, par_err_d, frm_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        timer_d   = fall ? '0 : timer_q + 1'b1;
        byte_ok   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fall && !dat) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: if (fall) begin
                shift_d   = {dat, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall) begin
                par_d   = dat;
                state_d = STOP;
            end
            STOP: if (fall) begin
                state_d = IDLE;
                if (!dat)                     frm_err_d = 1'b1;
                else if (!(^{shift_q, par_q})) par_err_d = 1'b1;
                else                          byte_ok   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A stalled device aborts the frame; a fall on the same cycle wins.
        if (state_q != IDLE && !fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = IDLE;
            timer_d   = '0;
            frm_err_d = 1'b1;
        end
    end

    logic push_req;
`ifdef BREAK_FILTER_EN
    logic ext_flag, brk_flag;
    logic is_prefix;

    assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);
    assign push_req  = byte_ok && !is_prefix && !brk_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end
`else
    assign push_req = byte_ok;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    assign full       = (count == (AW + 1)'(FIFO_DEPTH));
    assign pop        = rd_en && (count != '0);
    assign push       = push_req && (!full || pop);
    assign code_valid = (count != '0);
    assign scan_code  = code_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            parity_err <= par_err_d;
            frame_err  <= frm_err_d;
            overflow   <= push_req && full && !pop;
        end
    end
endmodule
